// File: rtl/air_hockey_pkg.sv
// rtl/air_hockey_pkg.sv - shared states, board geometry and field widths for the air-hockey datapath
package air_hockey_pkg;

    typedef enum logic [3:0] {
        IDLE, SERVE, PLAY, SNAP, WALL, D1X, D1Y, D2X, D2Y, APPLY, OVER
    } seq_state_e;

    localparam int COORD_W  = 10;
    localparam int SPD_W    = 4;
    localparam int DIR_W    = 1;
    localparam int SCORE_W  = 4;

    localparam int BRD_X0   = 194;
    localparam int BRD_X1   = 737;
    localparam int BRD_Y0   = 71;
    localparam int BRD_Y1   = 473;
    localparam int MOUTH_Y0 = 222;
    localparam int MOUTH_Y1 = 322;
    localparam int CENTER_X = 465;
    localparam int CENTER_Y = 272;

    function automatic logic [SPD_W-1:0] sat_inc(input logic [SPD_W-1:0] v,
                                                 input logic [SPD_W-1:0] max);
        return (v >= max) ? v : v + SPD_W'(1);
    endfunction

endpackage

// File: rtl/dist_sq.sv
// rtl/dist_sq.sv - signed 11x11 squarer with a 22-bit clear/accumulate register
module dist_sq (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [9:0]  a_i,
    input  logic [9:0]  b_i,
    input  logic        clr_i,
    input  logic        acc_i,
    output logic [21:0] sum_o
);
    logic signed [10:0] diff;
    logic [9:0]         mag;
    logic [20:0]        sq;
    logic [21:0]        sum_q;

    // |a-b| never exceeds 1023, so the magnitude fits 10 bits and its square 21 bits
    assign diff  = $signed({1'b0, a_i}) - $signed({1'b0, b_i});
    assign mag   = diff[10] ? 10'(-diff) : diff[9:0];
    assign sq    = 21'(mag) * 21'(mag);
    assign sum_o = sum_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sum_q <= '0;
        end else if (clr_i) begin
            sum_q <= 22'(sq);
        end else if (acc_i) begin
            sum_q <= sum_q + 22'(sq);
        end
    end
endmodule

// File: rtl/puck_sequencer.sv
// rtl/puck_sequencer.sv - per-frame wall/goal/paddle evaluation and scoring; PUCK_SEQ_SPEEDUP_EN adds paddle speed-up
module puck_sequencer
    import air_hockey_pkg::*;
#(
    parameter int BOARD_X0     = BRD_X0,
    parameter int BOARD_X1     = BRD_X1,
    parameter int BOARD_Y0     = BRD_Y0,
    parameter int BOARD_Y1     = BRD_Y1,
    parameter int GOAL_Y0      = MOUTH_Y0,
    parameter int GOAL_Y1      = MOUTH_Y1,
    parameter int PUCK_R       = 10,
    parameter int HIT_R2       = 625,
    parameter int SERVE_SPD_X  = 3,
    parameter int SERVE_SPD_Y  = 2,
    parameter int MAX_SPD      = 15,
    parameter int SERVE_FRAMES = 30,
    parameter int WIN_SCORE    = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               start,
    input  logic [COORD_W-1:0] puck_x,
    input  logic [COORD_W-1:0] puck_y,
    input  logic [COORD_W-1:0] dot_x_1,
    input  logic [COORD_W-1:0] dot_y_1,
    input  logic [COORD_W-1:0] dot_x_2,
    input  logic [COORD_W-1:0] dot_y_2,
    output logic [SPD_W-1:0]   speed_x,
    output logic [SPD_W-1:0]   speed_y,
    output logic               dir_x,
    output logic               dir_y,
    output logic               load,
    output logic [COORD_W-1:0] load_x,
    output logic [COORD_W-1:0] load_y,
    output logic [SCORE_W-1:0] score_1,
    output logic [SCORE_W-1:0] score_2,
    output logic [1:0]         winner,
    output logic               vel_upd,
    output logic               busy
);
    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);
`ifdef PUCK_SEQ_SPEEDUP_EN
    localparam logic SPEEDUP = 1'b1;
`else
    localparam logic SPEEDUP = 1'b0;
`endif

    seq_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [COORD_W-1:0] px_q, py_q, p1x_q, p1y_q, p2x_q, p2y_q;
    logic [COORD_W-1:0] px_d, py_d, p1x_d, p1y_d, p2x_d, p2y_d;
    logic [SPD_W-1:0]   spd_x_q, spd_x_d, spd_y_q, spd_y_d;
    logic               dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic               pdir_x_q, pdir_x_d, pdir_y_q, pdir_y_d;
    logic               hit1_q, hit1_d, load_q, load_d, vel_q, vel_d;
    logic [SCORE_W-1:0] sc1_q, sc1_d, sc2_q, sc2_d, nxt1, nxt2;
    logic [1:0]         win_q, win_d;

    logic [COORD_W-1:0] dist_a, dist_b;
    logic               dist_clr, dist_acc, hit_now;
    logic [21:0]        dist_sum;
    logic               left_c, right_c, top_c, bot_c, mouth;

    dist_sq u_dist (
        .clk_i(clk), .rst_i(rst), .a_i(dist_a), .b_i(dist_b),
        .clr_i(dist_clr), .acc_i(dist_acc), .sum_o(dist_sum)
    );

    // contact tests are done at 11 bits so puck_x + PUCK_R cannot wrap
    assign left_c  = {1'b0, px_q} <= 11'(BOARD_X0 + PUCK_R);
    assign right_c = ({1'b0, px_q} + 11'(PUCK_R)) >= 11'(BOARD_X1);
    assign top_c   = {1'b0, py_q} <= 11'(BOARD_Y0 + PUCK_R);
    assign bot_c   = ({1'b0, py_q} + 11'(PUCK_R)) >= 11'(BOARD_Y1);
    assign mouth   = (py_q >= 10'(GOAL_Y0)) && (py_q <= 10'(GOAL_Y1));
    assign hit_now = dist_sum < 22'(HIT_R2);
    assign nxt1    = (sc1_q >= 4'(WIN_SCORE)) ? sc1_q : sc1_q + 4'd1;
    assign nxt2    = (sc2_q >= 4'(WIN_SCORE)) ? sc2_q : sc2_q + 4'd1;

    always_comb begin
        state_d = state_q;  cnt_d = cnt_q;
        px_d = px_q;  py_d = py_q;  p1x_d = p1x_q;  p1y_d = p1y_q;  p2x_d = p2x_q;  p2y_d = p2y_q;
        spd_x_d = spd_x_q;  spd_y_d = spd_y_q;  dir_x_d = dir_x_q;  dir_y_d = dir_y_q;
        pdir_x_d = pdir_x_q;  pdir_y_d = pdir_y_q;  hit1_d = hit1_q;
        sc1_d = sc1_q;  sc2_d = sc2_q;  win_d = win_q;
        load_d = 1'b0;  vel_d = 1'b0;
        dist_a = px_q;  dist_b = p1x_q;  dist_clr = 1'b0;  dist_acc = 1'b0;
        case (state_q)
            IDLE, OVER: if (start) begin
                sc1_d = '0;  sc2_d = '0;  win_d = 2'b00;
                load_d = 1'b1;  dir_x_d = 1'b1;  cnt_d = '0;
                state_d = SERVE;
            end
            SERVE: if (tick) begin
                if (cnt_q == CNT_W'(SERVE_FRAMES - 1)) begin
                    spd_x_d = SPD_W'(SERVE_SPD_X);  spd_y_d = SPD_W'(SERVE_SPD_Y);
                    vel_d = 1'b1;  state_d = PLAY;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PLAY: if (tick) state_d = SNAP;
            SNAP: begin
                px_d = puck_x;  py_d = puck_y;  p1x_d = dot_x_1;  p1y_d = dot_y_1;
                p2x_d = dot_x_2;  p2y_d = dot_y_2;
                state_d = WALL;
            end
            WALL: begin
                if (left_c && mouth) begin
                    sc2_d = nxt2;  spd_x_d = '0;  spd_y_d = '0;
                    if (nxt2 == 4'(WIN_SCORE)) begin
                        win_d = 2'b10;  state_d = OVER;
                    end else begin
                        load_d = 1'b1;  dir_x_d = 1'b1;  cnt_d = '0;  state_d = SERVE;
                    end
                end else if (right_c && mouth) begin
                    sc1_d = nxt1;  spd_x_d = '0;  spd_y_d = '0;
                    if (nxt1 == 4'(WIN_SCORE)) begin
                        win_d = 2'b01;  state_d = OVER;
                    end else begin
                        load_d = 1'b1;  dir_x_d = 1'b0;  cnt_d = '0;  state_d = SERVE;
                    end
                end else begin
                    pdir_x_d = left_c ? 1'b1 : (right_c ? 1'b0 : dir_x_q);
                    pdir_y_d = top_c  ? 1'b1 : (bot_c   ? 1'b0 : dir_y_q);
                    state_d  = D1X;
                end
            end
            D1X: begin dist_clr = 1'b1; state_d = D1Y; end
            D1Y: begin dist_a = py_q; dist_b = p1y_q; dist_acc = 1'b1; state_d = D2X; end
            D2X: begin
                // accumulator still holds paddle 1's sum on this cycle
                hit1_d = hit_now;  dist_b = p2x_q;  dist_clr = 1'b1;  state_d = D2Y;
            end
            D2Y: begin dist_a = py_q; dist_b = p2y_q; dist_acc = 1'b1; state_d = APPLY; end
            APPLY: begin
                if (hit1_q) begin
                    dir_x_d = px_q >= p1x_q;  dir_y_d = py_q >= p1y_q;
                end else if (hit_now) begin
                    dir_x_d = px_q >= p2x_q;  dir_y_d = py_q >= p2y_q;
                end else begin
                    dir_x_d = pdir_x_q;  dir_y_d = pdir_y_q;
                end
                if (SPEEDUP && (hit1_q || hit_now)) begin
                    spd_x_d = sat_inc(spd_x_q, SPD_W'(MAX_SPD));
                    spd_y_d = sat_inc(spd_y_q, SPD_W'(MAX_SPD));
                end
                vel_d = 1'b1;  state_d = PLAY;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;  cnt_q <= '0;
            px_q <= '0;  py_q <= '0;  p1x_q <= '0;  p1y_q <= '0;  p2x_q <= '0;  p2y_q <= '0;
            spd_x_q <= '0;  spd_y_q <= '0;  dir_x_q <= 1'b1;  dir_y_q <= 1'b1;
            pdir_x_q <= 1'b1;  pdir_y_q <= 1'b1;  hit1_q <= 1'b0;
            load_q <= 1'b0;  vel_q <= 1'b0;  sc1_q <= '0;  sc2_q <= '0;  win_q <= 2'b00;
        end else begin
            state_q <= state_d;  cnt_q <= cnt_d;
            px_q <= px_d;  py_q <= py_d;  p1x_q <= p1x_d;  p1y_q <= p1y_d;  p2x_q <= p2x_d;  p2y_q <= p2y_d;
            spd_x_q <= spd_x_d;  spd_y_q <= spd_y_d;  dir_x_q <= dir_x_d;  dir_y_q <= dir_y_d;
            pdir_x_q <= pdir_x_d;  pdir_y_q <= pdir_y_d;  hit1_q <= hit1_d;
            load_q <= load_d;  vel_q <= vel_d;  sc1_q <= sc1_d;  sc2_q <= sc2_d;  win_q <= win_d;
        end
    end

    assign speed_x = spd_x_q;
    assign speed_y = spd_y_q;
    assign dir_x   = dir_x_q;
    assign dir_y   = dir_y_q;
    assign load    = load_q;
    assign load_x  = 10'(CENTER_X);
    assign load_y  = 10'(CENTER_Y);
    assign score_1 = sc1_q;
    assign score_2 = sc2_q;
    assign winner  = win_q;
    assign vel_upd = vel_q;
    assign busy    = state_q inside {SNAP, WALL, D1X, D1Y, D2X, D2Y, APPLY};
endmodule

// File: tb/tb_puck_sequencer.sv
// tb/tb_puck_sequencer.sv - self-checking bench for puck_sequencer
module tb_puck_sequencer;
    logic       clk = 1'b0;
    logic       rst, tick, start;
    logic [9:0] puck_x, puck_y, dot_x_1, dot_y_1, dot_x_2, dot_y_2;
    logic [3:0] speed_x, speed_y, score_1, score_2;
    logic       dir_x, dir_y, load, vel_upd, busy;
    logic [9:0] load_x, load_y;
    logic [1:0] winner;

    int checks = 0;
    int failures = 0;
    int exp_sx, exp_sy, vcount;

    typedef struct {
        logic [9:0] px, py, ax, ay, bx, by;
        logic       hit, ex, ey;
    } vec_t;
    vec_t vecs[9];

    always #5 clk = ~clk;

    puck_sequencer dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start),
        .puck_x(puck_x), .puck_y(puck_y),
        .dot_x_1(dot_x_1), .dot_y_1(dot_y_1), .dot_x_2(dot_x_2), .dot_y_2(dot_y_2),
        .speed_x(speed_x), .speed_y(speed_y), .dir_x(dir_x), .dir_y(dir_y),
        .load(load), .load_x(load_x), .load_y(load_y),
        .score_1(score_1), .score_2(score_2), .winner(winner),
        .vel_upd(vel_upd), .busy(busy)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pos(input logic [9:0] px, py, ax, ay, bx, by);
        puck_x = px;  puck_y = py;  dot_x_1 = ax;  dot_y_1 = ay;  dot_x_2 = bx;  dot_y_2 = by;
    endtask

    // after return the bench sits in cycle 1 relative to the tick
    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic serve();
        for (int i = 0; i < 30; i++) begin
            pulse_tick();
            if (i == 28) check("serve_wait_speed", int'(speed_x), 0);
            if (i == 29) begin
                check("serve_vel_pulse", int'(vel_upd), 1);
                check("serve_speed_x", int'(speed_x), 3);
                check("serve_speed_y", int'(speed_y), 2);
            end
            step();
            if (i == 29) check("serve_vel_end", int'(vel_upd), 0);
        end
    endtask

    task automatic run_eval(input int idx, input logic ex, input logic ey);
        pulse_tick();
        check($sformatf("v%0d_busy_c1", idx), int'(busy), 1);
        repeat (6) step();
        check($sformatf("v%0d_vel_c7", idx), int'(vel_upd), 0);
        check($sformatf("v%0d_busy_c7", idx), int'(busy), 1);
        step();
        check($sformatf("v%0d_vel_c8", idx), int'(vel_upd), 1);
        check($sformatf("v%0d_dir_x", idx), int'(dir_x), int'(ex));
        check($sformatf("v%0d_dir_y", idx), int'(dir_y), int'(ey));
        check($sformatf("v%0d_speed_x", idx), int'(speed_x), exp_sx);
        check($sformatf("v%0d_speed_y", idx), int'(speed_y), exp_sy);
        check($sformatf("v%0d_busy_c8", idx), int'(busy), 0);
        check($sformatf("v%0d_scores", idx), int'({score_1, score_2}), 0);
        step();
    endtask

    initial begin
        // wall bounces, paddle priority, the HIT_R2 boundary, paddle-over-wall
        vecs[0] = '{10'd730, 10'd150, 10'd600, 10'd450, 10'd600, 10'd450, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{10'd200, 10'd100, 10'd600, 10'd450, 10'd600, 10'd450, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{10'd400, 10'd470, 10'd600, 10'd450, 10'd600, 10'd450, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{10'd400, 10'd75,  10'd600, 10'd450, 10'd600, 10'd450, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{10'd400, 10'd300, 10'd600, 10'd450, 10'd410, 10'd310, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{10'd400, 10'd300, 10'd390, 10'd290, 10'd410, 10'd310, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{10'd400, 10'd300, 10'd415, 10'd320, 10'd600, 10'd450, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{10'd400, 10'd300, 10'd424, 10'd305, 10'd600, 10'd450, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{10'd200, 10'd100, 10'd210, 10'd110, 10'd600, 10'd450, 1'b1, 1'b0, 1'b0};

        rst = 1'b1;  tick = 1'b0;  start = 1'b0;
        set_pos(10'd465, 10'd272, 10'd600, 10'd450, 10'd600, 10'd450);
        repeat (3) step();
        rst = 1'b0;
        step();
        check("rst_speed_x", int'(speed_x), 0);
        check("rst_speed_y", int'(speed_y), 0);
        check("rst_dir_x", int'(dir_x), 1);
        check("rst_dir_y", int'(dir_y), 1);
        check("rst_load", int'(load), 0);
        check("rst_vel_upd", int'(vel_upd), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_scores", int'({score_1, score_2}), 0);
        check("rst_winner", int'(winner), 0);
        check("load_x", int'(load_x), 465);
        check("load_y", int'(load_y), 272);

        start = 1'b1;
        step();
        start = 1'b0;
        check("start_load", int'(load), 1);
        step();
        check("start_load_end", int'(load), 0);
        serve();
        check("serve_dir_x", int'(dir_x), 1);

        exp_sx = 3;  exp_sy = 2;
        for (int i = 0; i < 9; i++) begin
            set_pos(vecs[i].px, vecs[i].py, vecs[i].ax, vecs[i].ay, vecs[i].bx, vecs[i].by);
`ifdef PUCK_SEQ_SPEEDUP_EN
            if (vecs[i].hit) begin
                exp_sx = (exp_sx >= 15) ? 15 : exp_sx + 1;
                exp_sy = (exp_sy >= 15) ? 15 : exp_sy + 1;
            end
`endif
            run_eval(i, vecs[i].ex, vecs[i].ey);
        end

        // left goal: player 2 scores, re-serve toward the right
        set_pos(10'd200, 10'd272, 10'd600, 10'd450, 10'd600, 10'd450);
        pulse_tick();
        step();
        check("lgoal_load_c2", int'(load), 0);
        check("lgoal_score_c2", int'(score_2), 0);
        step();
        check("lgoal_load_c3", int'(load), 1);
        check("lgoal_score_c3", int'(score_2), 1);
        check("lgoal_speed_x", int'(speed_x), 0);
        check("lgoal_speed_y", int'(speed_y), 0);
        check("lgoal_dir_x", int'(dir_x), 1);
        check("lgoal_score_1", int'(score_1), 0);
        step();
        check("lgoal_load_c4", int'(load), 0);
        serve();
        check("lgoal_reserve_dir", int'(dir_x), 1);

        // right goals up to the winning score
        set_pos(10'd735, 10'd250, 10'd600, 10'd450, 10'd600, 10'd450);
        for (int k = 1; k <= 6; k++) begin
            pulse_tick();
            repeat (2) step();
            check($sformatf("rgoal%0d_score", k), int'(score_1), k);
            check($sformatf("rgoal%0d_dir_x", k), int'(dir_x), 0);
            check($sformatf("rgoal%0d_load", k), int'(load), 1);
            serve();
        end
        pulse_tick();
        repeat (2) step();
        check("win_score_1", int'(score_1), 7);
        check("win_winner", int'(winner), 1);
        check("win_speed_x", int'(speed_x), 0);
        check("win_load", int'(load), 0);
        check("win_busy", int'(busy), 0);
        for (int k = 0; k < 3; k++) begin
            pulse_tick();
            repeat (9) step();
        end
        check("over_score_1", int'(score_1), 7);
        check("over_score_2", int'(score_2), 1);
        check("over_winner", int'(winner), 1);
        check("over_speed", int'({speed_x, speed_y}), 0);
        check("over_busy", int'(busy), 0);
        check("over_vel_upd", int'(vel_upd), 0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_load", int'(load), 1);
        check("restart_scores", int'({score_1, score_2}), 0);
        check("restart_winner", int'(winner), 0);
        step();
        serve();

        // second tick during evaluation is dropped
        set_pos(10'd400, 10'd300, 10'd600, 10'd450, 10'd410, 10'd310);
        pulse_tick();
        repeat (2) step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        vcount = 0;
        for (int c = 0; c < 20; c++) begin
            if (vel_upd) vcount++;
            step();
        end
        check("drop_vel_count", vcount, 1);
        check("drop_busy", int'(busy), 0);
        check("drop_dir", int'({dir_x, dir_y}), 0);

        // reset in the middle of an evaluation
        pulse_tick();
        repeat (3) step();
        rst = 1'b1;
        step();
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_speed", int'({speed_x, speed_y}), 0);
        check("mid_rst_dir", int'({dir_x, dir_y}), 3);
        check("mid_rst_pulses", int'({load, vel_upd}), 0);
        check("mid_rst_winner", int'(winner), 0);
        rst = 1'b0;
        repeat (3) step();
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_vel", int'(vel_upd), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
